// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the word-address width derivation.
// No logic lives here; it is imported by the responder and its RAM.
package data_mem_responder_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of word-address bits needed to index a storage of 'depth' words.
    function automatic int word_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port synchronous word RAM with write enable and registered read.
// Latency: read data valid one cycle after an enabled read edge.
// Backpressure: none; the read register holds its value until the next enabled read.
module word_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clock,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // One access per enabled edge: either commit a write or capture a read.
    always_ff @(posedge clock) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: accepts one load/store, waits, then responds.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept edge.
// Backpressure: response and its data hold until rsp_ready; no new accept meanwhile.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = word_addr_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               ld_ok_q, ld_ok_d;

    logic               accept;
    logic               go_resp;
    logic               cur_write;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [16:0]        cur_word_ext;
    logic               cur_err;
    logic               ram_en;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait cycles the storage is accessed on the accept edge itself,
    // so the live request fields are used instead of the not-yet-latched copy.
    assign cur_write    = (state_q == IDLE) ? req_write : wr_q;
    assign cur_addr     = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata    = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_word_ext = {1'b0, cur_addr[17:2]};
    assign cur_err      = (cur_addr[1:0] != 2'b00) || (cur_word_ext >= 17'(DEPTH_WORDS));

    assign ram_en = go_resp && !cur_err;
    assign ram_we = ram_en && cur_write;

    // Loads expose the RAM read register; stores and errors return zero.
    assign rsp_rdata = ld_ok_q ? ram_rdata : '0;
    assign rsp_error = err_q;

    // Next-state and datapath capture decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ld_ok_d = ld_ok_q;
        go_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        go_resp = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    go_resp = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response status is frozen on the edge entering RESP and held after.
        if (go_resp) begin
            err_d   = cur_err;
            ld_ok_d = !cur_err && !cur_write;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ld_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ld_ok_q <= ld_ok_d;
        end
    end

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_word_ram (
        .clock   (clock),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a word-array model.
// Covers latency, errors, backpressure, reset in WAIT/RESP and zero-wait throughput.
// Responses are released by the bench; the zero-wait instance has rsp_ready tied high.
module tb_data_mem_responder;

    localparam int WAITC = 2;
    localparam int DEPTH = 256;

    logic        clock;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [17:0] b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_error;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus a "has been written" flag.
    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];

    data_mem_responder #(.WAIT_CYCLES(WAITC), .DEPTH_WORDS(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error)
    );

    assign b_rsp_ready = 1'b1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_is_err(input logic [17:0] a);
        return (a[1:0] != 2'b00) || (int'(a[17:2]) >= DEPTH);
    endfunction

    // One full transaction on the WAIT_CYCLES instance, holding rsp_ready low for 'hold' cycles.
    task automatic txn(input logic w, input logic [17:0] a, input logic [31:0] d,
                       input int hold, input string tag);
        bit          e;
        bit          check_rd;
        logic [31:0] exp_rd;
        logic [31:0] first;
        int          n;
        int          wi;
        e  = addr_is_err(a);
        wi = int'(a[17:2]);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = 18'($urandom); req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rsp_valid && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'(WAITC + 1));
        check_rd = 1'b1;
        exp_rd   = 32'd0;
        if (!e && w) begin
            mem_m[wi] = d;
            known[wi] = 1'b1;
        end else if (!e && !w) begin
            check_rd = known[wi];
            exp_rd   = mem_m[wi];
        end
        chk({tag, "_error"}, {31'b0, rsp_error}, {31'b0, e});
        if (check_rd) chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        first = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, check_rd ? exp_rd : first);
            chk({tag, "_hold_error"}, {31'b0, rsp_error}, {31'b0, e});
            chk({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, "_idle_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_idle_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] q_exp[$];
        logic [31:0] b_data [4];
        logic [31:0] got;
        logic        prev_acc;
        int          acc;
        logic [17:0] ra;
        int          kind;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b0;
        end

        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
        reset_n = 1'b1;

        // Store then load the same word; then a misaligned load and a re-read.
        txn(1'b1, 18'h00010, 32'hDEADBEEF, 0, "st10");
        txn(1'b0, 18'h00010, 32'h0, 0, "ld10");
        txn(1'b0, 18'h00012, 32'h0, 0, "ld12_misaligned");
        txn(1'b0, 18'h00010, 32'h0, 0, "ld10_again");

        // Out-of-range store must not disturb the boundary words.
        txn(1'b1, 18'h00000, 32'hA0A0A0A0, 0, "st_w0");
        txn(1'b1, 18'h003FC, 32'hFFFF0255, 0, "st_w255");
        txn(1'b1, 18'h00400, 32'hBAD0BAD0, 0, "st_oor");
        txn(1'b0, 18'h00000, 32'h0, 0, "ld_w0");
        txn(1'b0, 18'h003FC, 32'h0, 0, "ld_w255");

        // Backpressure: response held for five cycles.
        txn(1'b0, 18'h00010, 32'h0, 5, "ld10_hold");

        // Reset during WAIT abandons a pending store.
        txn(1'b1, 18'h00020, 32'h00000000, 0, "st20_pre");
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 18'h00020; req_wdata = 32'h12345678;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rstwait_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstwait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstwait_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("rstwait_no_rsp", {31'b0, rsp_valid}, 32'd0);
        txn(1'b0, 18'h00020, 32'h0, 0, "ld20_after_rst");

        // Reset during RESP keeps an already committed store.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 18'h00030; req_wdata = 32'hC0FFEE11;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (WAITC + 1) @(negedge clock);
        chk("rstresp_in_resp", {31'b0, rsp_valid}, 32'd1);
        mem_m[12] = 32'hC0FFEE11;
        known[12] = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rstresp_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstresp_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        txn(1'b0, 18'h00030, 32'h0, 0, "ld30_after_rst");

        // Randomized mix of loads, stores, misaligned and out-of-range accesses.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            ra   = 18'($urandom_range(0, 7) * 4);
            if (kind == 0) ra = ra + 18'($urandom_range(1, 3));
            else if (kind == 1) ra = 18'(($urandom_range(256, 600)) * 4);
            txn(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 2), "rnd");
        end

        // Zero-wait instance: 4 stores then 4 loads, fully back to back.
        for (int i = 0; i < 4; i++) b_data[i] = $urandom;
        acc = 0;
        prev_acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c > 0) begin
                chk("z_rsp_after_accept", {31'b0, b_rsp_valid}, {31'b0, prev_acc});
                chk("z_ready_pattern", {31'b0, b_req_ready}, {31'b0, !prev_acc});
            end
            if (b_rsp_valid) begin
                if (q_exp.size() == 0) begin
                    chk("z_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    got = q_exp.pop_front();
                    chk("z_rdata", b_rsp_rdata, got);
                    chk("z_error", {31'b0, b_rsp_error}, 32'd0);
                end
            end
            if (b_req_ready && acc < 8) begin
                b_req_valid = 1'b1;
                b_req_write = (acc < 4);
                b_req_addr  = 18'((40 + (acc % 4)) * 4);
                b_req_wdata = b_data[acc % 4];
                q_exp.push_back((acc < 4) ? 32'd0 : b_data[acc % 4]);
                acc++;
            end else if (b_req_ready) begin
                b_req_valid = 1'b0;
            end
            prev_acc = b_req_valid && b_req_ready;
        end
        chk("z_all_accepted", 32'(acc), 32'd8);
        chk("z_all_responded", 32'(q_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
